// File: rtl/inst_queue.sv
// Instruction queue between fetch and the register file: a circular FIFO of
// {inst, pc, pd} whose head entry is decoded and issued on registered outputs.
package inst_queue_pkg;
  typedef enum logic [5:0] {
    OP_NOP = 6'd0,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
  } op_e;
endpackage

module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr,
  input  logic        iIF_en,
  input  logic [31:0] iIF_inst,
  input  logic [31:0] iIF_pc,
  input  logic        iIF_pd,
  output logic        oIF_full,
  input  logic        iROB_full,
  input  logic        iRS_full,
  input  logic        iLSB_full,
  output logic        oRF_en,
  output logic [4:0]  oRF_rs1_regnm,
  output logic [4:0]  oRF_rs2_regnm,
  output logic [4:0]  oRF_rd_regnm,
  output logic [5:0]  oRF_op,
  output logic [31:0] oRF_pc,
  output logic [31:0] oRF_imm,
  output logic        oRF_pd
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pd;
  } entry_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;
  logic             stall, push_fire, pop_fire;

  assign oIF_full  = (count == FULL_CNT);
  assign stall     = iROB_full | iRS_full | iLSB_full;
  // Fullness uses pre-edge count, so a push at DEPTH is dropped even alongside a pop.
  assign push_fire = !rst && !clr && rdy && iIF_en && !oIF_full;
  assign pop_fire  = !rst && !clr && rdy && (count != '0) && !stall;

  // NOTE: queue storage has no reset; head/tail/count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_fire) mem[tail] <= '{inst: iIF_inst, pc: iIF_pc, pd: iIF_pd};
  end

  entry_t      hd;
  logic [31:0] ins;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign hd     = mem[head];
  assign ins    = hd.inst;
  assign opc    = ins[6:0];
  assign f3     = ins[14:12];
  assign f7     = ins[31:25];
  assign imm_i  = {{20{ins[31]}}, ins[31:20]};
  assign imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u  = {ins[31:12], 12'b0};
  assign imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  assign imm_sh = {27'b0, ins[24:20]};

  logic        d_legal;
  op_e         d_op;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic [31:0] d_imm;

  always_comb begin
    d_legal = 1'b1;
    d_op    = OP_NOP;
    d_rs1   = ins[19:15];
    d_rs2   = ins[24:20];
    d_rd    = ins[11:7];
    d_imm   = '0;
    case (opc)
      7'b0110111: begin d_op = OP_LUI;   d_rs1 = '0; d_rs2 = '0; d_imm = imm_u; end
      7'b0010111: begin d_op = OP_AUIPC; d_rs1 = '0; d_rs2 = '0; d_imm = imm_u; end
      7'b1101111: begin d_op = OP_JAL;   d_rs1 = '0; d_rs2 = '0; d_imm = imm_j; end
      7'b1100111: begin
        d_op = OP_JALR; d_rs2 = '0; d_imm = imm_i; d_legal = (f3 == 3'b000);
      end
      7'b1100011: begin
        d_rd = '0; d_imm = imm_b;
        case (f3)
          3'b000:  d_op = OP_BEQ;
          3'b001:  d_op = OP_BNE;
          3'b100:  d_op = OP_BLT;
          3'b101:  d_op = OP_BGE;
          3'b110:  d_op = OP_BLTU;
          3'b111:  d_op = OP_BGEU;
          default: d_legal = 1'b0;
        endcase
      end
      7'b0000011: begin
        d_rs2 = '0; d_imm = imm_i;
        case (f3)
          3'b000:  d_op = OP_LB;
          3'b001:  d_op = OP_LH;
          3'b010:  d_op = OP_LW;
          3'b100:  d_op = OP_LBU;
          3'b101:  d_op = OP_LHU;
          default: d_legal = 1'b0;
        endcase
      end
      7'b0100011: begin
        d_rd = '0; d_imm = imm_s;
        case (f3)
          3'b000:  d_op = OP_SB;
          3'b001:  d_op = OP_SH;
          3'b010:  d_op = OP_SW;
          default: d_legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        d_rs2 = '0; d_imm = imm_i;
        case (f3)
          3'b000: d_op = OP_ADDI;
          3'b010: d_op = OP_SLTI;
          3'b011: d_op = OP_SLTIU;
          3'b100: d_op = OP_XORI;
          3'b110: d_op = OP_ORI;
          3'b111: d_op = OP_ANDI;
          3'b001: begin d_op = OP_SLLI; d_imm = imm_sh; d_legal = (f7 == 7'h00); end
          default: begin
            d_imm = imm_sh;
            if (f7 == 7'h00)      d_op = OP_SRLI;
            else if (f7 == 7'h20) d_op = OP_SRAI;
            else                  d_legal = 1'b0;
          end
        endcase
      end
      7'b0110011: begin
        case ({f7, f3})
          {7'h00, 3'b000}: d_op = OP_ADD;
          {7'h20, 3'b000}: d_op = OP_SUB;
          {7'h00, 3'b001}: d_op = OP_SLL;
          {7'h00, 3'b010}: d_op = OP_SLT;
          {7'h00, 3'b011}: d_op = OP_SLTU;
          {7'h00, 3'b100}: d_op = OP_XOR;
          {7'h00, 3'b101}: d_op = OP_SRL;
          {7'h20, 3'b101}: d_op = OP_SRA;
          {7'h00, 3'b110}: d_op = OP_OR;
          {7'h00, 3'b111}: d_op = OP_AND;
          default:         d_legal = 1'b0;
        endcase
      end
      default: d_legal = 1'b0;
    endcase
    if (!d_legal) begin
      d_op  = OP_NOP;
      d_rs1 = '0;
      d_rs2 = '0;
      d_rd  = '0;
      d_imm = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push_fire) tail <= tail + 1'b1;
      if (pop_fire)  head <= head + 1'b1;
      case ({push_fire, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Outputs are zero on every cycle that does not carry a legal issued instruction.
  always_ff @(posedge clk) begin
    if (pop_fire && d_legal) begin
      oRF_en        <= 1'b1;
      oRF_rs1_regnm <= d_rs1;
      oRF_rs2_regnm <= d_rs2;
      oRF_rd_regnm  <= d_rd;
      oRF_op        <= d_op;
      oRF_pc        <= hd.pc;
      oRF_imm       <= d_imm;
      oRF_pd        <= hd.pd;
    end else begin
      oRF_en        <= 1'b0;
      oRF_rs1_regnm <= '0;
      oRF_rs2_regnm <= '0;
      oRF_rd_regnm  <= '0;
      oRF_op        <= '0;
      oRF_pc        <= '0;
      oRF_imm       <= '0;
      oRF_pd        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: expected issues are queued when pushed and
// compared in order by a negedge monitor; timing points are checked inline.
module tb_inst_queue;
  import inst_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, clr;
  logic        iIF_en;
  logic [31:0] iIF_inst, iIF_pc;
  logic        iIF_pd;
  logic        oIF_full;
  logic        iROB_full, iRS_full, iLSB_full;
  logic        oRF_en;
  logic [4:0]  oRF_rs1_regnm, oRF_rs2_regnm, oRF_rd_regnm;
  logic [5:0]  oRF_op;
  logic [31:0] oRF_pc, oRF_imm;
  logic        oRF_pd;

  inst_queue #(.DEPTH(16), .PTR_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .iIF_en(iIF_en), .iIF_inst(iIF_inst), .iIF_pc(iIF_pc), .iIF_pd(iIF_pd),
    .oIF_full(oIF_full),
    .iROB_full(iROB_full), .iRS_full(iRS_full), .iLSB_full(iLSB_full),
    .oRF_en(oRF_en),
    .oRF_rs1_regnm(oRF_rs1_regnm), .oRF_rs2_regnm(oRF_rs2_regnm),
    .oRF_rd_regnm(oRF_rd_regnm), .oRF_op(oRF_op),
    .oRF_pc(oRF_pc), .oRF_imm(oRF_imm), .oRF_pd(oRF_pd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc, imm;
    logic        pd;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   issued = 0;
  int   expected_issues = 0;
  bit   mon_on = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h required=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input op_e op, input logic [4:0] rs1, rs2, rd,
                              input logic [31:0] pc, imm, input logic pd);
    exp_t e;
    e.op = op; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.pc = pc; e.imm = imm; e.pd = pd;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one fetch word for one edge; enq marks it as one that must issue.
  task automatic drive(input logic [31:0] inst, pc, input logic pd, input bit enq, input exp_t e);
    iIF_en = 1'b1; iIF_inst = inst; iIF_pc = pc; iIF_pd = pd;
    if (enq) begin
      sb.push_back(e);
      expected_issues++;
    end
    tick();
    iIF_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (oRF_en) begin
        issued++;
        if (sb.size() == 0) check("unexpected_issue", 32'(oRF_en), 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("issue_op",  32'(oRF_op),        32'(e.op));
          check("issue_rs1", 32'(oRF_rs1_regnm), 32'(e.rs1));
          check("issue_rs2", 32'(oRF_rs2_regnm), 32'(e.rs2));
          check("issue_rd",  32'(oRF_rd_regnm),  32'(e.rd));
          check("issue_pc",  oRF_pc,             e.pc);
          check("issue_imm", oRF_imm,            e.imm);
          check("issue_pd",  32'(oRF_pd),        32'(e.pd));
        end
      end else begin
        check("idle_fields_zero",
              32'(|{oRF_op, oRF_rs1_regnm, oRF_rs2_regnm, oRF_rd_regnm, oRF_pc, oRF_imm, oRF_pd}),
              32'd0);
      end
    end
  end

  initial begin
    exp_t nul;
    logic [3:0] h_frz, t_frz;
    nul = '0;
    rst = 1'b1; rdy = 1'b1; clr = 1'b0;
    iIF_en = 1'b0; iIF_inst = '0; iIF_pc = '0; iIF_pd = 1'b0;
    iROB_full = 1'b0; iRS_full = 1'b0; iLSB_full = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("reset_en",    32'(oRF_en),   32'd0);
    check("reset_full",  32'(oIF_full), 32'd0);
    check("reset_count", 32'(dut.count), 32'd0);
    check("reset_fields", 32'(|{oRF_op, oRF_rs1_regnm, oRF_rs2_regnm, oRF_rd_regnm,
                                oRF_pc, oRF_imm, oRF_pd}), 32'd0);
    mon_on = 1'b1;

    // addi x1,x0,5 : latency and no bypass
    drive(32'h00500093, 32'h0, 1'b0, 1'b1, mk(OP_ADDI, 5'd0, 5'd0, 5'd1, 32'h0, 32'd5, 1'b0));
    check("addi_no_bypass", 32'(oRF_en), 32'd0);
    tick();
    check("addi_latency", 32'(oRF_en), 32'd1);
    tick();
    check("addi_pulse", 32'(oRF_en), 32'd0);

    // sw then beq, back to back
    drive(32'h0020A423, 32'h4, 1'b0, 1'b1, mk(OP_SW, 5'd1, 5'd2, 5'd0, 32'h4, 32'd8, 1'b0));
    drive(32'hFE208EE3, 32'h8, 1'b1, 1'b1,
          mk(OP_BEQ, 5'd1, 5'd2, 5'd0, 32'h8, 32'hFFFFFFFC, 1'b1));
    check("sw_issue", 32'(oRF_en), 32'd1);
    tick();
    check("beq_back_to_back", 32'(oRF_en), 32'd1);
    tick();
    check("beq_pulse", 32'(oRF_en), 32'd0);

    // lui x5,0x12345
    drive(32'h123452B7, 32'hC, 1'b0, 1'b1, mk(OP_LUI, 5'd0, 5'd0, 5'd5, 32'hC, 32'h12345000, 1'b0));
    tick(); tick();

    // jal / srai / illegal / add / lw stream
    drive(32'hFF9FF06F, 32'h10, 1'b1, 1'b1, mk(OP_JAL, 5'd0, 5'd0, 5'd0, 32'h10, 32'hFFFFFFF8, 1'b1));
    drive(32'h40725193, 32'h14, 1'b0, 1'b1, mk(OP_SRAI, 5'd4, 5'd0, 5'd3, 32'h14, 32'd7, 1'b0));
    drive(32'hFFFFFFFF, 32'h18, 1'b1, 1'b0, nul);
    drive(32'h007302B3, 32'h1C, 1'b0, 1'b1, mk(OP_ADD, 5'd6, 5'd7, 5'd5, 32'h1C, 32'd0, 1'b0));
    check("illegal_no_issue", 32'(oRF_en), 32'd0);
    drive(32'hFFC4A403, 32'h20, 1'b0, 1'b1, mk(OP_LW, 5'd9, 5'd0, 5'd8, 32'h20, 32'hFFFFFFFC, 1'b0));
    tick(); tick(); tick();
    check("stream_issue_count", 32'(issued), 32'(expected_issues));

    // Fill under stall, drop the 17th, drain across the pointer wrap
    iRS_full = 1'b1;
    for (int i = 0; i < 16; i++) begin
      int          iv;
      logic [31:0] ie;
      logic [11:0] f;
      iv = i * 37 - 300;
      ie = 32'(iv);
      f  = ie[11:0];
      drive({f, 5'(i), 3'b000, 5'(i + 1), 7'b0010011}, 32'h100 + 32'(4 * i), 1'(i % 2), 1'b1,
            mk(OP_ADDI, 5'(i), 5'd0, 5'(i + 1), 32'h100 + 32'(4 * i), ie, 1'(i % 2)));
      check("stalled_no_issue", 32'(oRF_en), 32'd0);
      if (i == 14) check("not_full_at_15", 32'(oIF_full), 32'd0);
    end
    check("full_at_16", 32'(oIF_full), 32'd1);
    drive(32'h00100093, 32'h200, 1'b0, 1'b0, nul);
    check("push17_dropped", 32'(dut.count), 32'd16);
    check("still_full", 32'(oIF_full), 32'd1);
    iRS_full = 1'b0;
    drive(32'h00200093, 32'h204, 1'b0, 1'b0, nul);
    check("drain_first", 32'(oRF_en), 32'd1);
    check("full_push_dropped_on_pop", 32'(dut.count), 32'd15);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("drain_consecutive", 32'(oRF_en), 32'd1);
    end
    tick();
    check("drain_done", 32'(oRF_en), 32'd0);

    // Each downstream full stalls issue but not push
    iROB_full = 1'b1;
    drive(32'h00A00513, 32'h300, 1'b0, 1'b1, mk(OP_ADDI, 5'd0, 5'd0, 5'd10, 32'h300, 32'd10, 1'b0));
    drive(32'hFFF00593, 32'h304, 1'b1, 1'b1,
          mk(OP_ADDI, 5'd0, 5'd0, 5'd11, 32'h304, 32'hFFFFFFFF, 1'b1));
    check("rob_stall", 32'(oRF_en), 32'd0);
    check("push_during_stall", 32'(dut.count), 32'd2);
    iROB_full = 1'b0; iLSB_full = 1'b1;
    tick();
    check("lsb_stall", 32'(oRF_en), 32'd0);
    iLSB_full = 1'b0;
    tick();
    check("stall_release_a", 32'(oRF_en), 32'd1);
    tick();
    check("stall_release_b", 32'(oRF_en), 32'd1);
    tick();

    // clr with a simultaneous push
    iRS_full = 1'b1;
    for (int i = 0; i < 5; i++) drive(32'h00100093, 32'h400 + 32'(4 * i), 1'b0, 1'b0, nul);
    check("clr_prefill", 32'(dut.count), 32'd5);
    clr = 1'b1; iRS_full = 1'b0;
    drive(32'h00300093, 32'h420, 1'b0, 1'b0, nul);
    clr = 1'b0;
    check("clr_en", 32'(oRF_en), 32'd0);
    check("clr_count", 32'(dut.count), 32'd0);
    check("clr_full", 32'(oIF_full), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("clr_nothing_issues", 32'(oRF_en), 32'd0);
    end
    drive(32'h00700393, 32'h500, 1'b1, 1'b1, mk(OP_ADDI, 5'd0, 5'd0, 5'd7, 32'h500, 32'd7, 1'b1));
    tick();
    check("post_clr_latency", 32'(oRF_en), 32'd1);
    tick();

    // rdy low for three cycles mid-stream
    for (int i = 0; i < 2; i++)
      drive({7'(i % 2 ? 7'h20 : 7'h00), 5'(i + 2), 5'(i + 1), 3'b000, 5'(i + 12), 7'b0110011},
            32'h600 + 32'(4 * i), 1'b0, 1'b1,
            mk(i % 2 ? OP_SUB : OP_ADD, 5'(i + 1), 5'(i + 2), 5'(i + 12),
               32'h600 + 32'(4 * i), 32'd0, 1'b0));
    check("rdy_pre_issue", 32'(oRF_en), 32'd1);
    h_frz = dut.head; t_frz = dut.tail;
    rdy = 1'b0; iIF_en = 1'b1; iIF_inst = 32'h00100093; iIF_pc = 32'h6F0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rdy_low_no_issue", 32'(oRF_en), 32'd0);
      check("rdy_low_head",     32'(dut.head), 32'(h_frz));
      check("rdy_low_tail",     32'(dut.tail), 32'(t_frz));
    end
    iIF_en = 1'b0; rdy = 1'b1;
    for (int i = 2; i < 6; i++)
      drive({7'(i % 2 ? 7'h20 : 7'h00), 5'(i + 2), 5'(i + 1), 3'b000, 5'(i + 12), 7'b0110011},
            32'h600 + 32'(4 * i), 1'b0, 1'b1,
            mk(i % 2 ? OP_SUB : OP_ADD, 5'(i + 1), 5'(i + 2), 5'(i + 12),
               32'h600 + 32'(4 * i), 32'd0, 1'b0));
    tick(); tick(); tick();

    // rst mid-stream discards queued entries
    iRS_full = 1'b1;
    for (int i = 0; i < 3; i++) drive(32'h00100093, 32'h700 + 32'(4 * i), 1'b0, 1'b0, nul);
    rst = 1'b1;
    tick();
    rst = 1'b0; iRS_full = 1'b0;
    check("rst_mid_count", 32'(dut.count), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_mid_no_issue", 32'(oRF_en), 32'd0);
    end

    check("total_issue_count", 32'(issued), 32'(expected_issues));
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
